// File: rtl/pingpong_game_ctrl_if.sv
// Player-key and display bundle for the ping-pong game controller.
// The key inputs (start, hit_l, hit_r) are single-cycle pulses with no
// back-pressure: a pulse is consumed on the edge that samples it or it is
// dropped. The display outputs are registered levels that are always valid.
interface pingpong_game_ctrl_if #(
    parameter int N_LED = 8
);
    logic             start;
    logic             hit_l;
    logic             hit_r;
    logic [N_LED-1:0] ball;
    logic [3:0]       score_l;
    logic [3:0]       score_r;
    logic [1:0]       winner;
    logic [2:0]       state;

    // Key/debouncer side: drives the pulses, watches the display outputs.
    modport master (
        output start, hit_l, hit_r,
        input  ball, score_l, score_r, winner, state
    );

    // Controller side.
    modport slave (
        input  start, hit_l, hit_r,
        output ball, score_l, score_r, winner, state
    );
endinterface

// File: rtl/pingpong_game_ctrl.sv
// Ping-pong game sequencer: serve, ball travel on a divided tick, hit
// windows at both ends, scoring and game end. Every output is a register
// updated in the same single FSM block that advances the state.
module pingpong_game_ctrl #(
    parameter int N_LED     = 8,
    parameter int TICK_DIV  = 25000000,
    parameter int SCORE_MAX = 9
) (
    input  logic                clk,
    input  logic                rst,
    pingpong_game_ctrl_if.slave bus
);
    localparam int PW = $clog2(N_LED);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [PW-1:0]    LAST   = PW'(N_LED - 1);
    localparam logic [CW-1:0]    TOP    = CW'(TICK_DIV - 1);
    localparam logic [3:0]       SMAX   = 4'(SCORE_MAX);
    localparam logic [N_LED-1:0] ALL_ON = '1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE_L   = 3'd1,
        SERVE_R   = 3'd2,
        MOVE_R    = 3'd3,
        MOVE_L    = 3'd4,
        POINT     = 3'd5,
        GAME_OVER = 3'd6
    } state_t;

    state_t           state_q;
    logic [PW-1:0]    pos_q;
    logic [CW-1:0]    cnt_q;
    logic [N_LED-1:0] ball_q;
    logic [3:0]       score_l_q;
    logic [3:0]       score_r_q;
    logic [1:0]       winner_q;
    logic             left_scored_q;  // who took the point currently on hold
    logic             tick;

    function automatic logic [N_LED-1:0] onehot(input logic [PW-1:0] p);
        logic [N_LED-1:0] one;
        one = {{(N_LED-1){1'b0}}, 1'b1};
        return one << p;
    endfunction

    // Step/hold strobe: last cycle of each TICK_DIV-long period.
    assign tick = (cnt_q == TOP);

    // Game FSM; every transition clears the tick counter so each new
    // step or hold lasts a full period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pos_q         <= '0;
            cnt_q         <= '0;
            ball_q        <= '0;
            score_l_q     <= '0;
            score_r_q     <= '0;
            winner_q      <= 2'b00;
            left_scored_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q  <= '0;
                    ball_q <= '0;
                    if (bus.start) begin
                        state_q   <= SERVE_L;
                        pos_q     <= '0;
                        ball_q    <= onehot('0);
                        score_l_q <= '0;
                        score_r_q <= '0;
                        winner_q  <= 2'b00;
                    end
                end

                SERVE_L: begin
                    cnt_q  <= '0;
                    pos_q  <= '0;
                    ball_q <= onehot('0);
                    if (bus.hit_l) begin
                        state_q <= MOVE_R;
                    end
                end

                SERVE_R: begin
                    cnt_q  <= '0;
                    pos_q  <= LAST;
                    ball_q <= onehot(LAST);
                    if (bus.hit_r) begin
                        state_q <= MOVE_L;
                    end
                end

                MOVE_R: begin
                    if (bus.hit_r && pos_q == LAST) begin
                        state_q <= MOVE_L;
                        cnt_q   <= '0;
                    end else if (bus.hit_r) begin
                        // Early strike by the right player.
                        state_q       <= POINT;
                        cnt_q         <= '0;
                        score_l_q     <= score_l_q + 4'd1;
                        left_scored_q <= 1'b1;
                    end else if (tick) begin
                        cnt_q <= '0;
                        if (pos_q == LAST) begin
                            state_q       <= POINT;
                            score_l_q     <= score_l_q + 4'd1;
                            left_scored_q <= 1'b1;
                        end else begin
                            pos_q  <= pos_q + PW'(1);
                            ball_q <= onehot(pos_q + PW'(1));
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                MOVE_L: begin
                    if (bus.hit_l && pos_q == '0) begin
                        state_q <= MOVE_R;
                        cnt_q   <= '0;
                    end else if (bus.hit_l) begin
                        // Early strike by the left player.
                        state_q       <= POINT;
                        cnt_q         <= '0;
                        score_r_q     <= score_r_q + 4'd1;
                        left_scored_q <= 1'b0;
                    end else if (tick) begin
                        cnt_q <= '0;
                        if (pos_q == '0) begin
                            state_q       <= POINT;
                            score_r_q     <= score_r_q + 4'd1;
                            left_scored_q <= 1'b0;
                        end else begin
                            pos_q  <= pos_q - PW'(1);
                            ball_q <= onehot(pos_q - PW'(1));
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                POINT: begin
                    // Ball stays frozen where the point ended.
                    if (tick) begin
                        cnt_q <= '0;
                        if (score_l_q == SMAX || score_r_q == SMAX) begin
                            state_q  <= GAME_OVER;
                            ball_q   <= ALL_ON;
                            winner_q <= (score_l_q == SMAX) ? 2'b01 : 2'b10;
                        end else if (left_scored_q) begin
                            state_q <= SERVE_R;
                            pos_q   <= LAST;
                            ball_q  <= onehot(LAST);
                        end else begin
                            state_q <= SERVE_L;
                            pos_q   <= '0;
                            ball_q  <= onehot('0);
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                GAME_OVER: begin
                    cnt_q  <= '0;
                    ball_q <= ALL_ON;
                    if (bus.start) begin
                        state_q   <= SERVE_L;
                        pos_q     <= '0;
                        ball_q    <= onehot('0);
                        score_l_q <= '0;
                        score_r_q <= '0;
                        winner_q  <= 2'b00;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    pos_q   <= '0;
                    cnt_q   <= '0;
                    ball_q  <= '0;
                end
            endcase
        end
    end

    assign bus.ball    = ball_q;
    assign bus.score_l = score_l_q;
    assign bus.score_r = score_r_q;
    assign bus.winner  = winner_q;
    assign bus.state   = state_q;
endmodule

// File: tb/tb_pingpong_game_ctrl.sv
// Directed bench for pingpong_game_ctrl with N_LED=8, TICK_DIV=4, SCORE_MAX=3.
// Inputs change 1 time unit after a rising edge; outputs are read there too.
module tb_pingpong_game_ctrl;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    pingpong_game_ctrl_if #(.N_LED(8)) bus ();

    pingpong_game_ctrl #(
        .N_LED(8),
        .TICK_DIV(4),
        .SCORE_MAX(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic s, input logic l, input logic r);
        bus.start = s;
        bus.hit_l = l;
        bus.hit_r = r;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.hit_l = 1'b0;
        bus.hit_r = 1'b0;
    endtask

    task automatic restart();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        pulse(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
        checks++; if (bus.ball !== 8'h00) begin errors++; $display("FAIL reset_ball got=%h exp=00", bus.ball); end
        checks++; if (bus.score_l !== 4'd0 || bus.score_r !== 4'd0) begin errors++; $display("FAIL reset_scores got=%0d/%0d exp=0/0", bus.score_l, bus.score_r); end
        checks++; if (bus.winner !== 2'b00) begin errors++; $display("FAIL reset_winner got=%b exp=00", bus.winner); end
        rst = 1'b0;
        step(1);
        checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL idle_hold got=%0d exp=0", bus.state); end
        pulse(1'b1, 1'b0, 1'b0);
        checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL start_state got=%0d exp=1", bus.state); end
        checks++; if (bus.ball !== 8'h01) begin errors++; $display("FAIL start_ball got=%h exp=01", bus.ball); end
        checks++; if (bus.score_l !== 4'd0 || bus.score_r !== 4'd0 || bus.winner !== 2'b00) begin errors++; $display("FAIL start_clear got=%0d/%0d/%b exp=0/0/00", bus.score_l, bus.score_r, bus.winner); end
        // Asynchronous reset in the middle of a clock period.
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL async_rst_state got=%0d exp=0", bus.state); end
        checks++; if (bus.ball !== 8'h00) begin errors++; $display("FAIL async_rst_ball got=%h exp=00", bus.ball); end
        step(1);
        rst = 1'b0;
    endtask

    task automatic test_rally();
        logic [7:0] exp_ball;
        restart();
        pulse(1'b0, 1'b1, 1'b0);
        checks++; if (bus.state !== 3'd3 || bus.ball !== 8'h01) begin errors++; $display("FAIL serve_hit got=%0d/%h exp=3/01", bus.state, bus.ball); end
        for (int k = 1; k < 8; k++) begin
            step(3);
            exp_ball = 8'h01 << (k - 1);
            checks++; if (bus.ball !== exp_ball) begin errors++; $display("FAIL rally_hold%0d got=%h exp=%h", k, bus.ball, exp_ball); end
            step(1);
            exp_ball = 8'h01 << k;
            checks++; if (bus.ball !== exp_ball) begin errors++; $display("FAIL rally_step%0d got=%h exp=%h", k, bus.ball, exp_ball); end
        end
        pulse(1'b0, 1'b0, 1'b1);
        checks++; if (bus.state !== 3'd4 || bus.ball !== 8'h80) begin errors++; $display("FAIL return_r got=%0d/%h exp=4/80", bus.state, bus.ball); end
        step(3);
        checks++; if (bus.ball !== 8'h80) begin errors++; $display("FAIL return_hold got=%h exp=80", bus.ball); end
        step(1);
        checks++; if (bus.ball !== 8'h40 || bus.state !== 3'd4) begin errors++; $display("FAIL return_step got=%h/%0d exp=40/4", bus.ball, bus.state); end
    endtask

    task automatic test_miss();
        restart();
        pulse(1'b0, 1'b1, 1'b0);
        step(28);
        checks++; if (bus.ball !== 8'h80 || bus.state !== 3'd3) begin errors++; $display("FAIL miss_arrive got=%h/%0d exp=80/3", bus.ball, bus.state); end
        step(3);
        checks++; if (bus.state !== 3'd3 || bus.score_l !== 4'd0) begin errors++; $display("FAIL miss_dwell got=%0d/%0d exp=3/0", bus.state, bus.score_l); end
        step(1);
        checks++; if (bus.state !== 3'd5 || bus.score_l !== 4'd1 || bus.score_r !== 4'd0 || bus.ball !== 8'h80) begin errors++; $display("FAIL miss_point got=%0d/%0d/%0d/%h exp=5/1/0/80", bus.state, bus.score_l, bus.score_r, bus.ball); end
        step(3);
        checks++; if (bus.state !== 3'd5 || bus.ball !== 8'h80) begin errors++; $display("FAIL miss_hold got=%0d/%h exp=5/80", bus.state, bus.ball); end
        step(1);
        checks++; if (bus.state !== 3'd2 || bus.ball !== 8'h80) begin errors++; $display("FAIL miss_serve_r got=%0d/%h exp=2/80", bus.state, bus.ball); end
        pulse(1'b0, 1'b1, 1'b0);
        checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL serve_r_ignore_l got=%0d exp=2", bus.state); end
        pulse(1'b0, 1'b0, 1'b1);
        checks++; if (bus.state !== 3'd4 || bus.ball !== 8'h80) begin errors++; $display("FAIL serve_r_hit got=%0d/%h exp=4/80", bus.state, bus.ball); end
        // Left player misses: mirror image.
        step(28);
        checks++; if (bus.ball !== 8'h01 || bus.state !== 3'd4) begin errors++; $display("FAIL miss_l_arrive got=%h/%0d exp=01/4", bus.ball, bus.state); end
        step(4);
        checks++; if (bus.state !== 3'd5 || bus.score_l !== 4'd1 || bus.score_r !== 4'd1 || bus.ball !== 8'h01) begin errors++; $display("FAIL miss_l_point got=%0d/%0d/%0d/%h exp=5/1/1/01", bus.state, bus.score_l, bus.score_r, bus.ball); end
        step(4);
        checks++; if (bus.state !== 3'd1 || bus.ball !== 8'h01) begin errors++; $display("FAIL miss_l_serve got=%0d/%h exp=1/01", bus.state, bus.ball); end
    endtask

    task automatic test_early_strike();
        restart();
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        checks++; if (bus.state !== 3'd3 || bus.ball !== 8'h01 || bus.score_l !== 4'd0) begin errors++; $display("FAIL ignore_l_start got=%0d/%h/%0d exp=3/01/0", bus.state, bus.ball, bus.score_l); end
        step(10);
        checks++; if (bus.ball !== 8'h08) begin errors++; $display("FAIL early_pos got=%h exp=08", bus.ball); end
        pulse(1'b0, 1'b0, 1'b1);
        checks++; if (bus.state !== 3'd5 || bus.score_l !== 4'd1 || bus.score_r !== 4'd0 || bus.ball !== 8'h08) begin errors++; $display("FAIL early_point got=%0d/%0d/%0d/%h exp=5/1/0/08", bus.state, bus.score_l, bus.score_r, bus.ball); end
        pulse(1'b1, 1'b0, 1'b0);
        checks++; if (bus.state !== 3'd5) begin errors++; $display("FAIL point_ignore_start got=%0d exp=5", bus.state); end
        step(3);
        checks++; if (bus.state !== 3'd2 || bus.ball !== 8'h80) begin errors++; $display("FAIL early_serve_r got=%0d/%h exp=2/80", bus.state, bus.ball); end
    endtask

    task automatic test_boundary();
        restart();
        pulse(1'b0, 1'b1, 1'b1);
        checks++; if (bus.state !== 3'd3 || bus.ball !== 8'h01 || bus.score_l !== 4'd0) begin errors++; $display("FAIL both_keys_serve got=%0d/%h/%0d exp=3/01/0", bus.state, bus.ball, bus.score_l); end
        step(31);
        pulse(1'b0, 1'b0, 1'b1);
        checks++; if (bus.state !== 3'd4 || bus.score_l !== 4'd0 || bus.ball !== 8'h80) begin errors++; $display("FAIL hit_on_tick got=%0d/%0d/%h exp=4/0/80", bus.state, bus.score_l, bus.ball); end
        step(4);
        checks++; if (bus.ball !== 8'h40) begin errors++; $display("FAIL hit_on_tick_step got=%h exp=40", bus.ball); end
    endtask

    task automatic test_win();
        restart();
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        checks++; if (bus.state !== 3'd5 || bus.score_l !== 4'd1) begin errors++; $display("FAIL win_pt1 got=%0d/%0d exp=5/1", bus.state, bus.score_l); end
        step(4);
        for (int p = 2; p <= 3; p++) begin
            pulse(1'b0, 1'b0, 1'b1);
            step(28);
            pulse(1'b0, 1'b1, 1'b0);
            pulse(1'b0, 1'b0, 1'b1);
            checks++; if (bus.state !== 3'd5 || bus.score_l !== 4'(p)) begin errors++; $display("FAIL win_pt%0d got=%0d/%0d exp=5/%0d", p, bus.state, bus.score_l, p); end
            step(4);
        end
        checks++; if (bus.state !== 3'd6 || bus.winner !== 2'b01 || bus.ball !== 8'hFF) begin errors++; $display("FAIL game_over got=%0d/%b/%h exp=6/01/ff", bus.state, bus.winner, bus.ball); end
        checks++; if (bus.score_l !== 4'd3 || bus.score_r !== 4'd0) begin errors++; $display("FAIL final_score got=%0d/%0d exp=3/0", bus.score_l, bus.score_r); end
        pulse(1'b0, 1'b1, 1'b1);
        checks++; if (bus.state !== 3'd6 || bus.winner !== 2'b01) begin errors++; $display("FAIL over_hold got=%0d/%b exp=6/01", bus.state, bus.winner); end
        pulse(1'b1, 1'b0, 1'b0);
        checks++; if (bus.state !== 3'd1 || bus.ball !== 8'h01 || bus.score_l !== 4'd0 || bus.score_r !== 4'd0 || bus.winner !== 2'b00) begin errors++; $display("FAIL new_game got=%0d/%h/%0d/%0d/%b exp=1/01/0/0/00", bus.state, bus.ball, bus.score_l, bus.score_r, bus.winner); end
    endtask

    // Test sequence and final report.
    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.hit_l = 1'b0;
        bus.hit_r = 1'b0;
        test_reset();
        test_rally();
        test_miss();
        test_early_strike();
        test_boundary();
        test_win();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
